// File: rtl/ula_pkg.sv
// Shared types for the ULA command driver: opcodes, driver states and the
// bit positions of the {v,c,n,z} flag nibble returned with each response.
package ula_pkg;

  typedef enum logic [1:0] {
    ULA_ADD = 2'b00,
    ULA_SUB = 2'b01,
    ULA_AND = 2'b10,
    ULA_OR  = 2'b11
  } ula_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } drv_state_e;

  localparam int FLG_V = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  // Latency counter width; covers ALU_LATENCY up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/ula_cmd_driver.sv
// Initiator for the registered ULA: takes one command at a time, presents it to the
// ULA, waits out the ULA latency, then holds the tagged result until it is consumed.
module ula_cmd_driver
  import ula_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [1:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_v,
  input  logic               alu_c,
  input  logic               alu_n,
  input  logic               alu_z,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY);

  drv_state_e        state_q, state_d;
  logic [LAT_W-1:0]  cnt_q;
  logic [TAG_W-1:0]  tag_q;
  logic              accept;
  logic              capture;
  logic              rsp_done;
  logic [3:0]        flags_now;

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_comb begin
    flags_now        = '0;
    flags_now[FLG_V] = alu_v;
    flags_now[FLG_C] = alu_c;
    flags_now[FLG_N] = alu_n;
    flags_now[FLG_Z] = alu_z;
  end

  // The ULA registers operands one edge after we drive them, so the result for a
  // latency of L is stable after L edges and is sampled on edge L+1 (cnt reaches 0).
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= LAT_LOAD;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - LAT_W'(1);
      end
    end
  end

  // Operands stay on the ULA bus after completion; only a new command replaces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 2'b00;
      tag_q  <= '0;
    end else if (accept) begin
      alu_a  <= cmd_a;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
      tag_q  <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
    end else if (capture) begin
      rsp_result <= alu_result;
      rsp_flags  <= flags_now;
      rsp_tag    <= tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_done) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule
